// File: rtl/snake_game_ctrl_if.sv
// ============================================================================
// Module   : snake_game_ctrl_if
// Purpose  : Control/status bundle between the snake game sequencer and the
//            button logic / snake datapath.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface snake_game_ctrl_if #(
  parameter int NUM_LEN  = 10,
  parameter int LEN_BITS = 4
);
  logic                start;
  logic [3:0]          dir_req;
  logic [NUM_LEN-1:0]  head_pos;
  logic                should_stop;
  logic                step;
  logic [1:0]          di;
  logic [LEN_BITS-1:0] len;
  logic [NUM_LEN-1:0]  food_pos;
  logic [7:0]          score;
  logic                restart;
  logic [2:0]          state;
  logic                game_over;

  // master = the game sequencer, slave = the surrounding game logic
  modport master (
    input  start, dir_req, head_pos, should_stop,
    output step, di, len, food_pos, score, restart, state, game_over
  );

  modport slave (
    output start, dir_req, head_pos, should_stop,
    input  step, di, len, food_pos, score, restart, state, game_over
  );
endinterface

`default_nettype wire

// File: rtl/snake_game_ctrl.sv
// ============================================================================
// Module   : snake_game_ctrl
// Purpose  : Snake game sequencer: move strobe, direction commit, collision /
//            food judgement, length, score and food placement.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module snake_game_ctrl #(
  parameter int MAX_LEN  = 16,
  parameter int NUM_LEN  = 10,
  parameter int WIDTH    = 32,
  parameter int HEIGHT   = 24,
  parameter int LEN_BITS = 4,
  parameter int INIT_LEN = 3,
  parameter int TICK_DIV = 1000000
) (
  input wire logic          clk,
  input wire logic          rst,
  snake_game_ctrl_if.master ctrl
);

  localparam int c_CNT_W     = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int c_LEN_TOP   = (2**LEN_BITS) - 1;
  // never report more segments than the body vector can hold
  localparam int c_LEN_SAT_I = (c_LEN_TOP < MAX_LEN) ? c_LEN_TOP : MAX_LEN;

  localparam logic [LEN_BITS-1:0] c_LEN_SAT   = LEN_BITS'(c_LEN_SAT_I);
  localparam logic [LEN_BITS-1:0] c_INIT_LEN  = LEN_BITS'(INIT_LEN);
  localparam logic [NUM_LEN-1:0]  c_CELLS     = NUM_LEN'(WIDTH * HEIGHT);
  localparam logic [NUM_LEN-1:0]  c_FOOD_INIT = NUM_LEN'(100);
  localparam logic [c_CNT_W-1:0]  c_CNT_LAST  = c_CNT_W'(TICK_DIV - 1);
  localparam logic [9:0]          c_LFSR_SEED = 10'h2A5;
  localparam logic [1:0]          c_DIR_RIGHT = 2'b01;
  localparam logic [7:0]          c_SCORE_MAX = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_CHECK = 3'd2,
    ST_FOOD  = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [c_CNT_W-1:0]  r_cnt;
  logic                r_phase;
  logic [1:0]          r_di;
  logic [1:0]          r_pend;
  logic [LEN_BITS-1:0] r_len;
  logic [7:0]          r_score;
  logic [NUM_LEN-1:0]  r_food;
  logic [9:0]          r_lfsr;
  logic                r_step;
  logic                r_restart;

  logic [1:0]          w_req_dir;
  logic                w_req_valid;
  logic                w_req_rev;
  logic                w_req_ok;
  logic                w_tick;
  logic                w_judge;
  logic                w_eat;
  logic [NUM_LEN-1:0]  w_cand;
  logic                w_place;
  logic                w_relaunch;

  always_comb begin
    w_req_dir = 2'b00;
    case (ctrl.dir_req)
      4'b0010: w_req_dir = 2'b01;
      4'b0100: w_req_dir = 2'b10;
      4'b1000: w_req_dir = 2'b11;
      default: w_req_dir = 2'b00;
    endcase
  end

  // a reversal keeps the axis bit and flips the sense bit
  assign w_req_valid = $onehot(ctrl.dir_req);
  assign w_req_rev   = (w_req_dir[1] == r_di[1]) && (w_req_dir[0] != r_di[0]);
  assign w_req_ok    = w_req_valid && !w_req_rev && (r_state == ST_RUN);

  assign w_tick     = (r_state == ST_RUN) && (r_cnt == c_CNT_LAST);
  assign w_judge    = (r_state == ST_CHECK) && r_phase;
  assign w_eat      = w_judge && !ctrl.should_stop && (ctrl.head_pos == r_food);
  assign w_cand     = NUM_LEN'(r_lfsr);
  assign w_place    = (r_state == ST_FOOD) && (w_cand < c_CELLS) && (w_cand != ctrl.head_pos);
  assign w_relaunch = (r_state == ST_OVER) && ctrl.start;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (ctrl.start) w_state_next = ST_RUN;
      ST_RUN:   if (w_tick) w_state_next = ST_CHECK;
      ST_CHECK: begin
        if (w_judge) begin
          if (ctrl.should_stop) w_state_next = ST_OVER;
          else if (w_eat)       w_state_next = ST_FOOD;
          else                  w_state_next = ST_RUN;
        end
      end
      ST_FOOD:  if (w_place) w_state_next = ST_RUN;
      ST_OVER:  if (ctrl.start) w_state_next = ST_RUN;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_phase   <= 1'b0;
      r_di      <= c_DIR_RIGHT;
      r_pend    <= c_DIR_RIGHT;
      r_len     <= c_INIT_LEN;
      r_score   <= '0;
      r_food    <= c_FOOD_INIT;
      r_lfsr    <= c_LFSR_SEED;
      r_step    <= 1'b0;
      r_restart <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_lfsr    <= {r_lfsr[8:0], r_lfsr[9] ^ r_lfsr[6]};
      r_step    <= w_tick;
      r_restart <= w_relaunch;
      r_phase   <= (r_state == ST_CHECK) ? ~r_phase : 1'b0;

      if (r_state == ST_RUN)
        r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      else if (ctrl.start && (r_state == ST_IDLE || r_state == ST_OVER))
        r_cnt <= '0;

      if (w_req_ok)
        r_pend <= w_req_dir;
      // a request landing on the tick cycle wins over the older pending one
      if (w_tick)
        r_di <= w_req_ok ? w_req_dir : r_pend;

      if (w_eat) begin
        if (r_len < c_LEN_SAT)     r_len   <= r_len + 1'b1;
        if (r_score != c_SCORE_MAX) r_score <= r_score + 1'b1;
      end

      if (w_place)
        r_food <= w_cand;

      if (w_relaunch) begin
        r_len   <= c_INIT_LEN;
        r_score <= '0;
        r_di    <= c_DIR_RIGHT;
        r_pend  <= c_DIR_RIGHT;
      end
    end
  end

  assign ctrl.step      = r_step;
  assign ctrl.di        = r_di;
  assign ctrl.len       = r_len;
  assign ctrl.food_pos  = r_food;
  assign ctrl.score     = r_score;
  assign ctrl.restart   = r_restart;
  assign ctrl.state     = r_state;
  assign ctrl.game_over = (r_state == ST_OVER);

endmodule

`default_nettype wire
